// File: rtl/reg_bus_reader_pkg.sv
// Shared constants and state encoding for the register-bank read sequencer.
// Bank geometry is common to the register bank, the bus model and the reader.
package reg_bus_reader_pkg;

    localparam int NREG = 4;
    localparam int W    = 8;
    localparam int AW   = 2;
    localparam int LW   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_CAP  = 2'd2,
        ST_VLD  = 2'd3
    } state_e;

endpackage

// File: rtl/reg_bus_reader_onehot_dec.sv
// Index-to-one-hot decoder with enable; all outputs low when en=0.
// Ports: en, idx[AW-1:0] in; onehot[NREG-1:0] out.
module onehot_dec #(
    parameter int AW   = 2,
    parameter int NREG = 4
) (
    input  logic            en,
    input  logic [AW-1:0]   idx,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bus_reader.sv
// Read-side sequencer: selects bank registers, settles, captures, hands off.
// Ports: clk, rst (async low), req/addr/blen, q_bank, ready in;
//        oe, dout, valid, busy, last out.
module reg_bus_reader #(
    parameter int NREG = reg_bus_reader_pkg::NREG,
    parameter int W    = reg_bus_reader_pkg::W,
    parameter int AW   = reg_bus_reader_pkg::AW,
    parameter int LW   = reg_bus_reader_pkg::LW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [AW-1:0]     addr,
    input  logic [LW-1:0]     blen,
    input  logic [NREG*W-1:0] q_bank,
    output logic [NREG-1:0]   oe,
    output logic [W-1:0]      dout,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              last
);

    import reg_bus_reader_pkg::*;

    state_e         state_q, state_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    ptr_d   = addr;
                    cnt_d   = blen;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                dout_d  = q_bank[int'(ptr_q)*W +: W];
                valid_d = 1'b1;
                last_d  = (cnt_q == '0);
                state_d = ST_VLD;
            end
            ST_VLD: begin
                if (ready) begin
                    valid_d = 1'b0;
                    if (cnt_q == '0) begin
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        // Index width equals log2(NREG), so +1 wraps the bank
                        cnt_d   = cnt_q - 1'b1;
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_SEL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Enable held across SEL and CAP from the same ptr, so no glitch between them
    onehot_dec #(
        .AW   (AW),
        .NREG (NREG)
    ) u_oe_dec (
        .en     ((state_q == ST_SEL) || (state_q == ST_CAP)),
        .idx    (ptr_q),
        .onehot (oe)
    );

    assign dout  = dout_q;
    assign valid = valid_q;
    assign last  = last_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_bus_reader.sv
// Self-checking bench for reg_bus_reader: directed cases plus random bursts
// checked against a word-list model of the bank.
module tb_reg_bus_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  addr;
    logic [1:0]  blen;
    logic [31:0] q_bank;
    logic [3:0]  oe;
    logic [7:0]  dout;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        last;

    logic [7:0]  bank [4];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always_comb q_bank = {bank[3], bank[2], bank[1], bank[0]};

    reg_bus_reader dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .addr   (addr),
        .blen   (blen),
        .q_bank (q_bank),
        .oe     (oe),
        .dout   (dout),
        .valid  (valid),
        .ready  (ready),
        .busy   (busy),
        .last   (last)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full burst from IDLE; stall<0 picks a random back-pressure per word,
    // and with mutate=1 the bank is scrambled while a word is held.
    task automatic do_burst(input logic [1:0] a, input logic [1:0] b,
                            input int stall, input bit mutate);
        int r;
        int n;
        logic [7:0] exp;
        logic [3:0] exp_oe;
        req  = 1'b1;
        addr = a;
        blen = b;
        tick();
        req  = 1'b0;
        addr = 2'($urandom);
        blen = 2'($urandom);
        for (int i = 0; i <= int'(b); i++) begin
            r      = (int'(a) + i) % 4;
            exp_oe = 4'b0001 << r;
            ready  = 1'($urandom);
            chk("sel_oe", 32'(oe), 32'(exp_oe));
            chk("sel_valid", 32'(valid), 0);
            chk("sel_busy", 32'(busy), 1);
            tick();
            chk("cap_oe", 32'(oe), 32'(exp_oe));
            chk("cap_valid", 32'(valid), 0);
            exp = bank[r];
            tick();
            chk("vld_valid", 32'(valid), 1);
            chk("vld_dout", 32'(dout), 32'(exp));
            chk("vld_last", 32'(last), 32'(i == int'(b)));
            chk("vld_oe", 32'(oe), 0);
            n = (stall < 0) ? int'($urandom_range(0, 4)) : stall;
            for (int k = 0; k < n; k++) begin
                ready = 1'b0;
                if (mutate) bank[$urandom_range(0, 3)] = 8'($urandom);
                tick();
                chk("stall_valid", 32'(valid), 1);
                chk("stall_dout", 32'(dout), 32'(exp));
                chk("stall_oe", 32'(oe), 0);
            end
            ready = 1'b1;
            tick();
            chk("acc_valid", 32'(valid), 0);
            chk("acc_busy", 32'(busy), 32'(i != int'(b)));
            chk("acc_dout", 32'(dout), 32'(exp));
        end
        ready = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        req   = 1'b0;
        addr  = '0;
        blen  = '0;
        ready = 1'b0;
        bank[0] = 8'h11;
        bank[1] = 8'h22;
        bank[2] = 8'h33;
        bank[3] = 8'h44;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oe", 32'(oe), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_dout", 32'(dout), 0);
        tick();
        rst = 1'b1;
        tick();

        do_burst(2'd1, 2'd0, 0, 1'b0);
        chk("t1_last_clr", 32'(last), 0);
        do_burst(2'd3, 2'd2, 0, 1'b0);
        do_burst(2'd0, 2'd1, 5, 1'b0);

        // req pulsed during CAP must not start a second burst
        req  = 1'b1;
        addr = 2'd0;
        blen = 2'd0;
        tick();
        req = 1'b0;
        tick();
        req  = 1'b1;
        addr = 2'd2;
        tick();
        req = 1'b0;
        chk("ign_dout", 32'(dout), 32'h11);
        chk("ign_last", 32'(last), 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("ign_idle", 32'(busy), 0);
        tick();
        chk("ign_no_burst", 32'(busy), 0);
        chk("ign_oe", 32'(oe), 0);

        // Asynchronous reset during SEL of the second word
        req   = 1'b1;
        addr  = 2'd0;
        blen  = 2'd1;
        ready = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        tick();
        chk("ar_pre_oe", 32'(oe), 32'b0010);
        #2 rst = 1'b0;
        #1;
        chk("ar_oe", 32'(oe), 0);
        chk("ar_valid", 32'(valid), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_dout", 32'(dout), 0);
        tick();
        rst = 1'b1;
        ready = 1'b0;
        tick();
        chk("ar_idle", 32'(busy), 0);
        do_burst(2'd2, 2'd0, 0, 1'b0);

        // Bank change while holding a word leaves dout alone
        req  = 1'b1;
        addr = 2'd1;
        blen = 2'd0;
        tick();
        req = 1'b0;
        tick();
        tick();
        bank[1] = 8'hAA;
        #1;
        chk("iso_dout", 32'(dout), 32'h22);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        do_burst(2'd1, 2'd0, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int j = 0; j < 4; j++) bank[j] = 8'($urandom);
            do_burst(2'($urandom), 2'($urandom), -1, 1'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
